matmul_stream_ctrl: RTL and testbench

//   Streaming front/back end for matrix_multiplication_accumulation (D = A*B + C).

---
 rtl/matmul_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_matmul_stream_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_ctrl.sv
// Streaming wrapper around a combinational MAC array computing D = A*B + C.
// Operands arrive serially (A, B, C row-major); D drains serially row-major.

module matmul_mac_cell #(
    parameter int K = 16,
    parameter int P = 8
) (
    input  logic [K-1:0][P-1:0] a,
    input  logic [K-1:0][P-1:0] b,
    input  logic [4*P-1:0]      c,
    output logic [4*P-1:0]      d
);
    localparam int W = 4 * P;

    logic signed [2*P-1:0] prod;
    logic signed [W-1:0]   acc;

    // Sign-extend to 2P before multiplying so the full product is kept; sum wraps at W bits.
    always_comb begin
        prod = '0;
        acc  = $signed(c);
        for (int k = 0; k < K; k++) begin
            prod = (2*P)'($signed(a[k])) * (2*P)'($signed(b[k]));
            acc  = acc + W'(prod);
        end
    end

    assign d = acc;
endmodule

module matmul_stream_ctrl #(
    parameter int M = 8,
    parameter int N = 4,
    parameter int K = 16,
    parameter int P = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*P-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*P-1:0] out_data,
    output logic           out_last,
    output logic           busy
);
    localparam int W     = 4 * P;
    localparam int MK    = M * K;
    localparam int KN    = K * N;
    localparam int MN    = M * N;
    localparam int MAXAB = (MK > KN) ? MK : KN;
    localparam int MAXS  = (MAXAB > MN) ? MAXAB : MN;
    localparam int CW    = $clog2(MAXS);
    localparam int AW    = $clog2(MK);
    localparam int BW    = $clog2(KN);
    localparam int DW    = $clog2(MN);

    typedef enum logic [2:0] {LOAD_A, LOAD_B, LOAD_C, COMPUTE, DRAIN} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [MK-1:0][P-1:0]   a_q;
    logic [KN-1:0][P-1:0]   b_q;
    logic [MN-1:0][W-1:0]   c_q;
    logic [MN-1:0][W-1:0]   d_q;
    logic [MN-1:0][W-1:0]   mac_d;
    logic                   cnt_last;
    logic                   in_xfer;
    logic                   out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        cnt_last = 1'b0;
        case (state)
            LOAD_A:  cnt_last = (cnt == CW'(MK - 1));
            LOAD_B:  cnt_last = (cnt == CW'(KN - 1));
            LOAD_C:  cnt_last = (cnt == CW'(MN - 1));
            DRAIN:   cnt_last = (cnt == CW'(MN - 1));
            default: cnt_last = 1'b0;
        endcase
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [K-1:0][P-1:0] arow;
            logic [K-1:0][P-1:0] bcol;
            for (genvar k = 0; k < K; k++) begin : g_k
                assign arow[k] = a_q[i*K + k];
                assign bcol[k] = b_q[k*N + j];
            end
            matmul_mac_cell #(.K(K), .P(P)) u_cell (
                .a (arow),
                .b (bcol),
                .c (c_q[i*N + j]),
                .d (mac_d[i*N + j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        a_q[cnt[AW-1:0]] <= in_data[P-1:0];
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        b_q[cnt[BW-1:0]] <= in_data[P-1:0];
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) state <= LOAD_C;
                    end
                end
                LOAD_C: begin
                    if (in_xfer) begin
                        c_q[cnt[DW-1:0]] <= in_data;
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    d_q       <= mac_d;
                    state     <= DRAIN;
                    out_valid <= 1'b1;
                end
                DRAIN: begin
                    if (out_xfer) begin
                        if (cnt_last) begin
                            state     <= LOAD_A;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    // Outputs are muxed from registered state so they hold while the consumer stalls.
    assign out_data = out_valid ? d_q[cnt[DW-1:0]] : '0;
    assign out_last = out_valid & (cnt == CW'(MN - 1));
    assign busy     = (state != LOAD_A) || (cnt != '0);
endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl: loads whole jobs and checks the drained D stream.

module tb_matmul_stream_ctrl;
    localparam int M = 8, N = 4, K = 16, P = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int vecs = 0;
    int errs = 0;
    int first_waits;

    matmul_stream_ctrl #(.M(M), .N(N), .K(K), .P(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a_val(input int kind, input int i, input int k);
        case (kind)
            1: return 32'h0000_0001;
            2: return 32'h5A5A_A5FF;
            3: return 32'h0000_0080;
            default: return 32'(i + k);
        endcase
    endfunction

    function automatic logic [31:0] b_val(input int kind, input int k, input int j);
        case (kind)
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FF7F;
            3: return 32'h0000_0080;
            default: return (k == j) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] c_val(input int kind, input int i);
        case (kind)
            1: return 32'd0;
            2: return 32'd5;
            3: return 32'h7FFF_FFFF;
            default: return 32'(10 * i);
        endcase
    endfunction

    function automatic logic [31:0] d_exp(input int kind, input int i, input int j);
        case (kind)
            1: return 32'd16;
            2: return -32'sd2027;
            3: return -32'sd2147221505;
            default: return 32'(11 * i + j);
        endcase
    endfunction

    task automatic push(input logic [31:0] v, input bit gaps, output int waits);
        bit ok = 1'b0;
        waits = 0;
        if (errs > 40) return;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = v;
        while (!ok && waits <= 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (!ok) waits++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            errs++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
        end
    endtask

    task automatic load_job(input int kind, input bit gaps, input int b_limit);
        int w;
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) begin
                push(a_val(kind, i, k), gaps, w);
                if (i == 0 && k == 0) first_waits = w;
            end
        for (int n = 0; n < K*N && n < b_limit; n++)
            push(b_val(kind, n / N, n % N), gaps, w);
        if (b_limit < K*N) return;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                push(c_val(kind, i), gaps, w);
    endtask

    task automatic drain(input int kind, input bit gaps);
        logic [31:0] held;
        bit          stalled = 1'b0;
        for (int idx = 0; idx < M*N; idx++) begin
            bit done = 1'b0;
            int w = 0;
            if (errs > 40) break;
            while (!done) begin
                out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (out_valid) begin
                    vecs++;
                    if (in_ready !== 1'b0) begin
                        errs++;
                        $display("FAIL in_ready_drain: got %b, required 0", in_ready);
                    end
                    if (stalled) begin
                        vecs++;
                        if (out_data !== held) begin
                            errs++;
                            $display("FAIL stall_hold: out_data %0h, required %0h", out_data, held);
                        end
                    end
                    if (out_ready) begin
                        vecs++;
                        if (out_data !== d_exp(kind, idx / N, idx % N) || out_last !== (idx == M*N-1)) begin
                            errs++;
                            $display("FAIL d_elem[%0d]: data %0d last %b, required %0d last %b", idx,
                                     $signed(out_data), out_last, $signed(d_exp(kind, idx / N, idx % N)), idx == M*N-1);
                        end
                        done    = 1'b1;
                        stalled = 1'b0;
                    end else begin
                        held    = out_data;
                        stalled = 1'b1;
                    end
                end
                w++;
                if (!done && w > 200) begin
                    errs++;
                    $display("FAIL drain_timeout: element %0d never transferred, out_valid %b", idx, out_valid);
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        vecs++;
        if ({in_ready, out_valid, out_last, busy} !== 4'b0000 || out_data !== 32'd0) begin
            errs++;
            $display("FAIL reset_outputs: rdy %b vld %b last %b busy %b data %0h, required all 0",
                     in_ready, out_valid, out_last, busy, out_data);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL post_reset: rdy %b busy %b vld %b, required 1 0 0", in_ready, busy, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ones();
        load_job(1, 1'b0, K*N);
        @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL compute_cycle: vld %b rdy %b busy %b, required 0 0 1", out_valid, in_ready, busy);
        end
        @(negedge clk);
        vecs++;
        if (out_valid !== 1'b1) begin
            errs++;
            $display("FAIL latency: out_valid %b two cycles after last C, required 1", out_valid);
        end
        @(posedge clk); #1;
        drain(1, 1'b0);
    endtask

    task automatic test_neg();
        load_job(2, 1'b0, K*N);
        drain(2, 1'b0);
    endtask

    task automatic test_wrap();
        load_job(3, 1'b0, K*N);
        drain(3, 1'b0);
    endtask

    task automatic test_stalls();
        load_job(4, 1'b1, K*N);
        drain(4, 1'b1);
    endtask

    task automatic test_mid_reset();
        load_job(1, 1'b0, 30);
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL busy_load_b: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset: vld %b busy %b rdy %b, required 0 0 0", out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_job(1, 1'b0, K*N);
        drain(1, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_job(2, 1'b0, K*N);
        drain(2, 1'b0);
        load_job(1, 1'b0, K*N);
        vecs++;
        if (first_waits != 0) begin
            errs++;
            $display("FAIL b2b_accept: first A waited %0d cycles, required 0", first_waits);
        end
        drain(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_neg();
        test_wrap();
        test_stalls();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
